// File: rtl/mux_pipe_reg_if.sv
// Bus bundle for mux_pipe_reg: channel inputs, pipeline controls and registered outputs.
// The master drives the stimulus side and the slave is the pipeline itself.
interface mux_pipe_reg_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int OCC_W  = 2
);
    logic [NUM_CH*WIDTH-1:0] d;
    logic [SEL_W-1:0]        sel;
    logic                    vld_in;
    logic                    en;
    logic                    flush;
    logic [WIDTH-1:0]        q;
    logic                    vld_out;
    logic [OCC_W-1:0]        occ;
    logic                    sel_err;

    modport master (
        output d, sel, vld_in, en, flush,
        input  q, vld_out, occ, sel_err
    );

    modport slave (
        input  d, sel, vld_in, en, flush,
        output q, vld_out, occ, sel_err
    );
endinterface

// File: rtl/mux_pipe_reg.sv
// NUM_CH:1 channel mux feeding a DEPTH-stage stallable delay line.
// Each stage carries a valid bit; tracks occupancy and a sticky select-error flag.
module mux_pipe_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 3,
    parameter int OCC_W  = 2
) (
    input  logic           clk,
    input  logic           rst,
    mux_pipe_reg_if.slave  bus
);
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             sel_err_q;
    logic             sel_err_d;

    logic [WIDTH-1:0] mux_word;
    logic             sel_ok;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        mux_word = bus.d[0 +: WIDTH];
        sel_ok   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.sel) == i) begin
                mux_word = bus.d[i*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        data_d    = data_q;
        vld_d     = vld_q;
        occ_d     = occ_q;
        sel_err_d = sel_err_q;
        if (bus.flush) begin
            vld_d = '0;
            occ_d = '0;
        end else if (bus.en) begin
            data_d[0] = mux_word;
            vld_d[0]  = bus.vld_in;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
            case ({bus.vld_in, vld_q[DEPTH-1]})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
            if (bus.vld_in && !sel_ok) begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q     <= '0;
            occ_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
            vld_q     <= vld_d;
            occ_q     <= occ_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.q       = data_q[DEPTH-1];
    assign bus.vld_out = vld_q[DEPTH-1];
    assign bus.occ     = occ_q;
    assign bus.sel_err = sel_err_q;
endmodule
